fsm_driver: RTL and testbench
=============================

FSM_DRIVER -- requirements
Module: fsm_driver

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exposure counter width.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 4, cycles allowed for a state change after a request.
REQ-003 SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse requesting a capture.
- abort  in  1  level; forces a return to IDLE.
- exp_time  in  EXP_W  exposure length in cycles, sampled at accepted start.
- conv_time  in  4  conversion length in cycles, sampled at accepted start.
- read_len  in  8  readout length in cycles, sampled at accepted start.
- current_state  in  2  registered state of the FSM core (00 IDLE, 01 EXPOSE, 10 CONVERT, 11 READ).
- op  out  1  transition request to the core.
- select  out  1  0 = advance, 1 = return to IDLE.
- busy  out  1  capture in progress.
- done  out  1  one-cycle pulse when a capture completes normally.
- err  out  1  sticky; set on acknowledge timeout.

Function
REQ-005 Core contract: op=0 means the core holds; op=1,select=0 means it advances 00->01->10->11->00; op=1,select=1 means it goes to 00.
REQ-006 Internal phases SHALL be WAIT_IDLE, DWELL, REQ and ACK.
REQ-007 In WAIT_IDLE with current_state=00, err=0 and start=1, SHALL latch exp_time/conv_time/read_len, assert busy and enter REQ.
REQ-008 In REQ, SHALL drive op=1,select=0 for exactly one cycle, record the expected next state, then enter ACK.
REQ-009 In ACK, SHALL drive op=0 and count cycles until current_state equals the expected state.
REQ-010 On a match in ACK, SHALL load the dwell counter with the latched time for the new state and enter DWELL.
- A latched time of 0 SHALL be treated as 1 cycle.
- Entering IDLE goes straight to WAIT_IDLE.
REQ-011 DWELL SHALL decrement once per cycle and enter REQ on the cycle the counter reaches 1.
REQ-012 Advance latency SHALL be exactly N cycles of dwell plus one REQ cycle per state.
REQ-013 After the READ->IDLE acknowledge, SHALL pulse done for one cycle and deassert busy in the same cycle.
REQ-014 If ACK runs ACK_TIMEOUT cycles without a match, SHALL set err and drive op=1,select=1 for one cycle.
- busy SHALL fall and no done is issued.
- err SHALL clear only on reset.
REQ-015 abort=1 while busy SHALL issue op=1,select=1 the next cycle, then wait for current_state=00.
- No done is issued.
- The abort path has the same ACK_TIMEOUT limit.
- abort has priority over a pending advance in the same cycle.
REQ-016 start while busy or while err=1 SHALL be ignored.
REQ-017 start and abort in the same cycle from WAIT_IDLE SHALL be ignored.
REQ-018 op SHALL never be high on two consecutive cycles.

Reset
REQ-019 During reset, SHALL set phase WAIT_IDLE, op=0, select=0, busy=0, done=0, err=0, and clear all counters and latched times.
REQ-020 Reset asserted mid-capture SHALL abandon the capture without issuing op.

Structure
REQ-021 A shared package SHALL hold the 2-bit state typedef (IDLE, EXPOSE, CONVERT, READ) and the select encodings.
- fsm_comb and fsm_driver SHALL both use this package.
REQ-022 One sub-module, dwell_counter (load, decrement, terminal flag), SHALL be used.
- Everything else SHALL be inline.

Verification
REQ-023 The bench SHALL close the loop: fsm_comb plus a state register, fed by op/select.
REQ-024 Directed scenarios:
- exp=3, conv=2, read=4, start -> states 01/10/11/00 with dwell 3/2/4; one done pulse; busy high 13 cycles after start.
- exp_time=0 -> EXPOSE lasts 1 cycle; sequence still completes with done.
- abort during CONVERT -> op=1,select=1 the next cycle; current_state=00; no done; busy low.
- Core state register frozen (no ack) -> err=1 after 4 cycles; op=1,select=1 pulse; later start ignored until reset.
- start during busy, and start with abort in the same cycle -> ignored; no extra op pulses.
- reset asserted mid-READ -> all outputs 0 immediately; next start runs a clean capture.

Source files
------------

// File: rtl/fsm_driver_pkg.sv
// Shared types for the capture driver and its FSM core.
// Core state encoding, driver phases and select codes.
package fsm_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_EXPOSE  = 2'b01,
    ST_CONVERT = 2'b10,
    ST_READ    = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    PH_WAIT_IDLE = 2'b00,
    PH_DWELL     = 2'b01,
    PH_REQ       = 2'b10,
    PH_ACK       = 2'b11
  } phase_e;

  localparam logic SEL_ADVANCE = 1'b0;
  localparam logic SEL_IDLE    = 1'b1;

  function automatic state_e next_state(
    input state_e s
  );
    state_e n;
    n = ST_IDLE;
    unique case (s)
      ST_IDLE:    n = ST_EXPOSE;
      ST_EXPOSE:  n = ST_CONVERT;
      ST_CONVERT: n = ST_READ;
      ST_READ:    n = ST_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fsm_comb.sv
// Next-state logic of the capture FSM core.
// Ports: state (current), op/select (request) -> state_next.
module fsm_comb
  import fsm_driver_pkg::*;
(
  input  logic [1:0] state,
  input  logic       op,
  input  logic       select,
  output logic [1:0] state_next
);

  always_comb begin
    state_next = state;
    if (op) begin
      if (select == SEL_IDLE)
        state_next = ST_IDLE;
      else
        state_next = next_state(state_e'(state));
    end
  end

endmodule

// File: rtl/fsm_driver_dwell_counter.sv
// Loadable down-counter timing the dwell in each core state.
// Ports: clk, reset, load/value, dec -> term (count is 1).
module dwell_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         term
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= value;
    else if (dec && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign term = (cnt == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/fsm_driver.sv
// Sequences the FSM core IDLE->EXPOSE->CONVERT->READ->IDLE.
// Ports: start/abort/times in; current_state fed back; op/select/busy/done/err out.
module fsm_driver
  import fsm_driver_pkg::*;
#(
  parameter int EXP_W       = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [EXP_W-1:0] exp_time,
  input  logic [3:0]       conv_time,
  input  logic [7:0]       read_len,
  input  logic [1:0]       current_state,
  output logic             op,
  output logic             select,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int DW = (EXP_W > 8) ? EXP_W : 8;
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);

  phase_e           phase, phase_n;
  state_e           want_q, want_n;
  logic             sel_q, sel_n;
  logic             fin_q, fin_n;
  logic             pend_q, pend_n;
  logic             err_q, err_n;
  logic [AW-1:0]    ack_q, ack_n;
  logic [EXP_W-1:0] exp_q, exp_n;
  logic [3:0]       conv_q, conv_n;
  logic [7:0]       read_q, read_n;

  state_e           cur;
  logic             match;
  logic             abort_go;
  logic             finish;
  logic [DW-1:0]    dwell_t;
  logic             cnt_load, cnt_dec, cnt_term;

  assign cur   = state_e'(current_state);
  assign match = (cur == want_q);

  // A pending or live abort preempts any advance while still going forward.
  assign abort_go = !sel_q && (abort || pend_q);
  assign finish   = (phase == PH_ACK) && !abort_go
                 && match && (want_q == ST_IDLE);

  always_comb begin
    dwell_t = '0;
    unique case (want_q)
      ST_EXPOSE:  dwell_t = DW'(exp_q);
      ST_CONVERT: dwell_t = DW'(conv_q);
      ST_READ:    dwell_t = DW'(read_q);
      default:    dwell_t = '0;
    endcase
  end

  // The acknowledging cycle already sits in the new state, so it is
  // the first dwell cycle; the counter only covers the remainder.
  dwell_counter #(.W(DW)) u_dwell (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .value (dwell_t - 1'b1),
    .term  (cnt_term)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase  <= PH_WAIT_IDLE;
      want_q <= ST_IDLE;
      sel_q  <= SEL_ADVANCE;
      fin_q  <= 1'b0;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
      ack_q  <= '0;
      exp_q  <= '0;
      conv_q <= '0;
      read_q <= '0;
    end else begin
      phase  <= phase_n;
      want_q <= want_n;
      sel_q  <= sel_n;
      fin_q  <= fin_n;
      pend_q <= pend_n;
      err_q  <= err_n;
      ack_q  <= ack_n;
      exp_q  <= exp_n;
      conv_q <= conv_n;
      read_q <= read_n;
    end
  end

  always_comb begin
    phase_n  = phase;
    want_n   = want_q;
    sel_n    = sel_q;
    fin_n    = fin_q;
    pend_n   = pend_q;
    err_n    = err_q;
    ack_n    = ack_q;
    exp_n    = exp_q;
    conv_n   = conv_q;
    read_n   = read_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (phase)
      PH_WAIT_IDLE: begin
        if (start && !abort && !err_q && cur == ST_IDLE) begin
          exp_n   = exp_time;
          conv_n  = conv_time;
          read_n  = read_len;
          sel_n   = SEL_ADVANCE;
          fin_n   = 1'b0;
          pend_n  = 1'b0;
          phase_n = PH_REQ;
        end
      end
      PH_REQ: begin
        want_n  = sel_q ? ST_IDLE : next_state(cur);
        ack_n   = '0;
        // op cannot repeat next cycle, so an abort here waits in ACK.
        pend_n  = abort && !sel_q;
        fin_n   = 1'b0;
        phase_n = fin_q ? PH_WAIT_IDLE : PH_ACK;
      end
      PH_ACK: begin
        if (abort_go) begin
          sel_n   = SEL_IDLE;
          pend_n  = 1'b0;
          phase_n = PH_REQ;
        end else if (match) begin
          if (want_q == ST_IDLE) begin
            phase_n = PH_WAIT_IDLE;
          end else if (dwell_t <= DW'(1)) begin
            sel_n   = SEL_ADVANCE;
            phase_n = PH_REQ;
          end else begin
            cnt_load = 1'b1;
            phase_n  = PH_DWELL;
          end
        end else if (ack_q == ACK_LAST) begin
          err_n   = 1'b1;
          sel_n   = SEL_IDLE;
          fin_n   = 1'b1;
          phase_n = PH_REQ;
        end else begin
          ack_n = ack_q + 1'b1;
        end
      end
      PH_DWELL: begin
        if (abort) begin
          sel_n   = SEL_IDLE;
          phase_n = PH_REQ;
        end else if (cnt_term) begin
          sel_n   = SEL_ADVANCE;
          phase_n = PH_REQ;
        end else begin
          cnt_dec = 1'b1;
        end
      end
    endcase
  end

  assign op     = (phase == PH_REQ);
  assign select = op && sel_q;
  assign busy   = (phase != PH_WAIT_IDLE) && !fin_q && !finish;
  assign done   = finish && !sel_q;
  assign err    = err_q;

endmodule

// File: tb/tb_fsm_driver.sv
// Closed-loop bench: fsm_driver driving fsm_comb plus a state register.
// Directed scenarios with hand-computed cycle counts.
module tb_fsm_driver;
  import fsm_driver_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] exp_time = '0;
  logic [3:0] conv_time = '0;
  logic [7:0] read_len = '0;
  logic [1:0] cs, cs_next;
  logic       op, select, busy, done, err;
  logic       freeze = 1'b0;

  int checks = 0;
  int errors = 0;

  int w_busy, w_done, w_op, w_d1, w_d2, w_d3;
  int w_dbl, w_db;

  always #5 clk = ~clk;

  fsm_driver #(.EXP_W(8), .ACK_TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .exp_time      (exp_time),
    .conv_time     (conv_time),
    .read_len      (read_len),
    .current_state (cs),
    .op            (op),
    .select        (select),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  fsm_comb u_core (
    .state      (cs),
    .op         (op),
    .select     (select),
    .state_next (cs_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cs <= 2'b00;
    else if (!freeze)
      cs <= cs_next;
  end

  task automatic pulse_start(input logic [7:0] e,
                             input logic [3:0] c,
                             input logic [7:0] r);
    @(negedge clk);
    exp_time  = e;
    conv_time = c;
    read_len  = r;
    start     = 1'b1;
  endtask

  // Observe n cycles; raise start again after sample index extra.
  task automatic run_window(input int n, input int extra);
    logic prev_op;
    prev_op = 1'b0;
    w_busy = 0; w_done = 0; w_op = 0;
    w_d1 = 0; w_d2 = 0; w_d3 = 0;
    w_dbl = 0; w_db = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) w_busy++;
      if (done) w_done++;
      if (done && busy) w_db = 1;
      if (op) w_op++;
      if (op && prev_op) w_dbl = 1;
      prev_op = op;
      if (cs == 2'b01) w_d1++;
      if (cs == 2'b10) w_d2++;
      if (cs == 2'b11) w_d3++;
      if (i == extra) start = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({op, select, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs got %b want 00000",
               {op, select, busy, done, err});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cs !== 2'b00) begin
      errors++;
      $display("FAIL post_reset busy=%b cs=%b want 0/00", busy, cs);
    end
  endtask

  task automatic test_sequence;
    pulse_start(8'd3, 4'd2, 8'd4);
    run_window(25, -1);
    checks++;
    if (w_busy !== 13) begin
      errors++;
      $display("FAIL seq_busy got %0d want 13", w_busy);
    end
    checks++;
    if (w_done !== 1 || w_db !== 0) begin
      errors++;
      $display("FAIL seq_done got %0d/%0d want 1/0", w_done, w_db);
    end
    checks++;
    if (w_op !== 4 || w_dbl !== 0) begin
      errors++;
      $display("FAIL seq_ops got %0d/%0d want 4/0", w_op, w_dbl);
    end
    checks++;
    if (w_d1 !== 4 || w_d2 !== 3 || w_d3 !== 5) begin
      errors++;
      $display("FAIL seq_dwell got %0d/%0d/%0d want 4/3/5",
               w_d1, w_d2, w_d3);
    end
  endtask

  task automatic test_exp_zero;
    pulse_start(8'd0, 4'd2, 8'd4);
    run_window(25, -1);
    checks++;
    if (w_d1 !== 2 || w_d2 !== 3 || w_d3 !== 5) begin
      errors++;
      $display("FAIL zero_dwell got %0d/%0d/%0d want 2/3/5",
               w_d1, w_d2, w_d3);
    end
    checks++;
    if (w_busy !== 11 || w_done !== 1) begin
      errors++;
      $display("FAIL zero_busy_done got %0d/%0d want 11/1",
               w_busy, w_done);
    end
  endtask

  task automatic test_abort;
    int found;
    found = 0;
    pulse_start(8'd3, 4'd5, 8'd2);
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (cs == 2'b10) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL abort_reach_convert got cs=%b want 10", cs);
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if (op !== 1'b1 || select !== 1'b1) begin
      errors++;
      $display("FAIL abort_req got op=%b sel=%b want 1/1", op, select);
    end
    abort = 1'b0;
    run_window(8, -1);
    checks++;
    if (w_busy !== 0 || w_done !== 0 || w_op !== 0) begin
      errors++;
      $display("FAIL abort_after got busy=%0d done=%0d op=%0d want 0/0/0",
               w_busy, w_done, w_op);
    end
    checks++;
    if (cs !== 2'b00 || err !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got cs=%b err=%b want 00/0", cs, err);
    end
  endtask

  task automatic test_timeout;
    freeze = 1'b1;
    pulse_start(8'd3, 4'd2, 8'd4);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (op !== 1'b1 || select !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL to_req got op=%b sel=%b busy=%b want 1/0/1",
               op, select, busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (err !== 1'b0 || op !== 1'b0) begin
      errors++;
      $display("FAIL to_early got err=%b op=%b want 0/0", err, op);
    end
    @(negedge clk);
    checks++;
    if ({err, op, select, busy} !== 4'b1110) begin
      errors++;
      $display("FAIL to_fire got %b want 1110",
               {err, op, select, busy});
    end
    freeze = 1'b0;
    pulse_start(8'd3, 4'd2, 8'd4);
    run_window(8, -1);
    checks++;
    if (w_op !== 0 || w_busy !== 0 || err !== 1'b1) begin
      errors++;
      $display("FAIL to_locked got op=%0d busy=%0d err=%b want 0/0/1",
               w_op, w_busy, err);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL to_clear got err=%b want 0", err);
    end
  endtask

  task automatic test_back_to_back;
    pulse_start(8'd3, 4'd2, 8'd4);
    run_window(25, 2);
    checks++;
    if (w_op !== 4 || w_busy !== 13 || w_done !== 1) begin
      errors++;
      $display("FAIL b2b got op=%0d busy=%0d done=%0d want 4/13/1",
               w_op, w_busy, w_done);
    end
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    run_window(6, -1);
    checks++;
    if (w_op !== 0 || w_busy !== 0) begin
      errors++;
      $display("FAIL start_abort got op=%0d busy=%0d want 0/0",
               w_op, w_busy);
    end
  endtask

  task automatic test_reset_mid;
    int found;
    found = 0;
    pulse_start(8'd1, 4'd1, 8'd6);
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (cs == 2'b11) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL rst_reach_read got cs=%b want 11", cs);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({op, select, busy, done, err} !== 5'b0 || cs !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid got %b cs=%b want 00000/00",
               {op, select, busy, done, err}, cs);
    end
    @(negedge clk);
    reset = 1'b0;
    pulse_start(8'd2, 4'd1, 8'd1);
    run_window(20, -1);
    checks++;
    if (w_busy !== 8 || w_done !== 1 || w_op !== 4) begin
      errors++;
      $display("FAIL rst_rerun got busy=%0d done=%0d op=%0d want 8/1/4",
               w_busy, w_done, w_op);
    end
    checks++;
    if (w_d1 !== 3 || w_d2 !== 2 || w_d3 !== 2) begin
      errors++;
      $display("FAIL rst_rerun_dwell got %0d/%0d/%0d want 3/2/2",
               w_d1, w_d2, w_d3);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_exp_zero();
    test_abort();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
